// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and burst-counter sizing for mem_arbiter
package mem_arb_pkg;
    typedef enum logic {RUN, HALT} state_t;
    typedef enum logic [1:0] {NONE, CPU, DBG} owner_t;
    localparam int BURST_MAX_DEF = 4;
    function automatic int burst_w(input int max_cnt);
        return $clog2(max_cnt + 1);
    endfunction
    localparam int BURST_W = burst_w(BURST_MAX_DEF);
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a 1-cycle-latency block RAM between the CPU memory path and a debug/loader port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DBG_BURST_MAX = BURST_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_stall,
    input  logic              dbg_halt,
    output logic              halted,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_oob
);
    localparam int CW = burst_w(DBG_BURST_MAX) > BURST_W ? burst_w(DBG_BURST_MAX) : BURST_W;
    state_t            state;
    owner_t            owner;
    logic [CW-1:0]     burst_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] cpu_hold, dbg_hold;
    logic              oob_q;
    logic              cpu_gnt, oob, burst_ok;

    assign oob       = |cpu_addr[31:ADDR_W+2];
    assign burst_ok  = burst_cnt < CW'(DBG_BURST_MAX);
    assign dbg_gnt   = dbg_req & ((state == HALT) | ~cpu_req | burst_ok);
    assign cpu_gnt   = cpu_req & (state == RUN) & ~dbg_gnt;
    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign halted    = state == HALT;
    // out-of-range CPU accesses still take the slot but never write
    assign mem_we    = cpu_gnt ? cpu_we & ~oob : dbg_gnt & dbg_we;
    assign mem_addr  = cpu_gnt ? cpu_addr[ADDR_W+1:2] : dbg_gnt ? dbg_addr : addr_q;
    assign mem_wdata = cpu_gnt ? cpu_wdata : dbg_wdata;
    assign cpu_rvalid = owner == CPU;
    assign dbg_rvalid = owner == DBG;
    assign cpu_rdata  = cpu_rvalid ? (oob_q ? '0 : mem_rdata) : cpu_hold;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            owner     <= NONE;
            burst_cnt <= '0;
            addr_q    <= '0;
            cpu_hold  <= '0;
            dbg_hold  <= '0;
            oob_q     <= 1'b0;
            err_oob   <= 1'b0;
        end else begin
            state     <= dbg_halt ? HALT : RUN;
            owner     <= cpu_gnt & ~cpu_we ? CPU : dbg_gnt & ~dbg_we ? DBG : NONE;
            burst_cnt <= (~cpu_req | cpu_gnt) ? '0 : (dbg_gnt & burst_ok) ? burst_cnt + 1'b1 : burst_cnt;
            addr_q    <= mem_addr;
            cpu_hold  <= cpu_rdata;
            dbg_hold  <= dbg_rdata;
            oob_q     <= oob;
            err_oob   <= err_oob | (cpu_gnt & oob);
        end
    end
endmodule
